xnor_match_unit: RTL and testbench
==================================

Name: xnor_match_unit

Overview:
- Parametrised, pipelined successor to the team's single-bit XNOR equality gate.
- Applies a selectable bitwise logic op (XNOR/AND/OR/XOR) to two WIDTH-bit operands.
- Reports popcount of the result and full-vector equality.
- Tracks a saturating count of consecutive equal samples.
- Sits on a valid-qualified data stream as a compare/match stage feeding checkers and counters.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 8, width of the consecutive-match streak counter (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands/mode valid this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- mode  input  2  op select: 00 XNOR, 01 AND, 10 OR, 11 XOR
- clr_streak  input  1  synchronous clear of streak counter
- out_valid  output  1  result outputs valid
- result  output  WIDTH  registered bitwise op result
- ones  output  $clog2(WIDTH+1)  number of 1 bits in result
- equal  output  1  1 when a==b for this sample (independent of mode)
- streak  output  CNT_W  consecutive valid samples with equal=1
- streak_sat  output  1  streak at 2^CNT_W-1

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: on a clk edge with rst=1, all pipeline valids, result, ones, equal, streak and streak_sat go to 0. In-flight samples are discarded. rst overrides all other inputs.
- Stage 1 (S1): on an edge with in_valid=1, capture op(a,b) per mode, plus eq1 = (a==b). s1_valid <= in_valid every edge; S1 data holds when in_valid=0.
- Stage 2 (S2, outputs): on an edge with s1_valid=1, register result, ones = popcount(result) and equal = eq1. out_valid <= s1_valid every edge. result/ones/equal hold their last value while out_valid=0.
- Latency: a sample presented before edge k appears on the outputs after edge k+1 (2 cycles).
- Throughput: 1 sample per cycle. No backpressure; downstream must accept every out_valid.
- Bubbles: in_valid gaps propagate as out_valid gaps. A bubble does not break the streak.
- Streak update is evaluated at the S2 edge, first matching rule wins:
  - clr_streak=1 and s1_valid=1: streak <= eq1 ? 1 : 0.
  - clr_streak=1 and s1_valid=0: streak <= 0.
  - s1_valid=1 and eq1=1: streak <= min(streak+1, 2^CNT_W-1). Saturates, no wrap.
  - s1_valid=1 and eq1=0: streak <= 0.
  - otherwise: hold.
- streak_sat is registered and equals (next streak == 2^CNT_W-1). It clears on the same edge streak leaves saturation.
- Mode change between consecutive samples takes effect per sample with no dead cycle.
- equal is unaffected by mode.
- ones width: $clog2(WIDTH+1), so all-ones WIDTH=8 gives ones=8 in 4 bits.
- No combinational path from any input to any output.

Test Plan:
- Reset/latency: rst for 2 cycles, then a=8'hA5, b=8'hA5, mode=00, single in_valid pulse. Required: all outputs 0 during reset; 2 edges after the pulse, out_valid=1 for exactly 1 cycle with result=8'hFF, ones=8, equal=1, streak=1.
- Modes: a=8'hF0, b=8'h3C back-to-back with mode 00/01/10/11. Required: results 8'h33, 8'h30, 8'hFC, 8'hCC; ones 4, 2, 6, 4; equal=0 each; streak=0.
- Streak with bubble: 3 equal samples, 2 idle cycles, 2 equal samples, then a=8'h01, b=8'h00. Required: streak 1, 2, 3, holds 3 through the bubble, then 4, 5, then 0 with equal=0.
- Saturation: CNT_W=2, 5 consecutive equal samples. Required: streak 1, 2, 3, 3, 3; streak_sat=1 from the 3rd sample; one unequal sample then gives streak=0, streak_sat=0.
- Clear collision: with streak=4, assert clr_streak on the edge where an equal sample reaches S2. Required: streak=1. Same with an unequal sample: streak=0. clr_streak with no valid: streak=0.
- Reset mid-stream: continuous equal stream, rst asserted 1 cycle with 2 samples in flight. Required: out_valid=0 and streak=0 the next cycle; the in-flight samples never appear; the first post-reset sample yields streak=1 with 2-cycle latency.

Source files
------------

// File: rtl/xnor_match_unit.sv
// rtl/xnor_match_unit.sv - two-stage bitwise compare/match stage with popcount and equality streak
module xnor_match_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [1:0]                 mode,
  input  logic                       clr_streak,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           result,
  output logic [$clog2(WIDTH+1)-1:0] ones,
  output logic                       equal,
  output logic [CNT_W-1:0]           streak,
  output logic                       streak_sat
);

  localparam int OW = $clog2(WIDTH+1);
  localparam logic [CNT_W-1:0] STREAK_MAX = '1;

  localparam logic [1:0] MODE_XNOR = 2'b00;
  localparam logic [1:0] MODE_AND  = 2'b01;
  localparam logic [1:0] MODE_OR   = 2'b10;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_eq;

  logic [WIDTH-1:0] op_value;
  logic [OW-1:0]    pop_count;
  logic [CNT_W-1:0] streak_next;

  always_comb begin
    op_value = a ^ b;
    case (mode)
      MODE_XNOR: op_value = ~(a ^ b);
      MODE_AND:  op_value = a & b;
      MODE_OR:   op_value = a | b;
      default:   op_value = a ^ b;
    endcase
  end

  // Stage 1: operation and equality capture; data holds across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_eq    <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= op_value;
        s1_eq   <= (a == b);
      end
    end
  end

  always_comb begin
    pop_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_count = pop_count + OW'(s1_data[i]);
    end
  end

  // A clear still counts an equal sample arriving on the same edge.
  always_comb begin
    streak_next = streak;
    if (clr_streak) begin
      streak_next = (s1_valid && s1_eq) ? CNT_W'(1) : '0;
    end else if (s1_valid) begin
      if (!s1_eq) begin
        streak_next = '0;
      end else if (streak != STREAK_MAX) begin
        streak_next = streak + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      result     <= '0;
      ones       <= '0;
      equal      <= 1'b0;
      streak     <= '0;
      streak_sat <= 1'b0;
    end else begin
      out_valid  <= s1_valid;
      streak     <= streak_next;
      streak_sat <= (streak_next == STREAK_MAX);
      if (s1_valid) begin
        result <= s1_data;
        ones   <= pop_count;
        equal  <= s1_eq;
      end
    end
  end

endmodule

// File: tb/tb_xnor_match_unit.sv
// tb/tb_xnor_match_unit.sv - randomized and directed checks of xnor_match_unit against a queue-based model
module tb_xnor_match_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] mode;
  logic       clr_streak;

  logic       out_valid, out_valid_s;
  logic [7:0] result, result_s;
  logic [3:0] ones, ones_s;
  logic       equal, equal_s;
  logic [7:0] streak;
  logic [1:0] streak_s;
  logic       streak_sat, streak_sat_s;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] m;
  } rec_t;

  rec_t q[$];

  logic       exp_ov;
  logic [7:0] exp_result;
  int         exp_ones;
  logic       exp_equal;
  int         exp_streak;
  int         exp_streak_s;

  xnor_match_unit #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .mode(mode),
    .clr_streak(clr_streak), .out_valid(out_valid), .result(result), .ones(ones),
    .equal(equal), .streak(streak), .streak_sat(streak_sat)
  );

  xnor_match_unit #(.WIDTH(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .mode(mode),
    .clr_streak(clr_streak), .out_valid(out_valid_s), .result(result_s), .ones(ones_s),
    .equal(equal_s), .streak(streak_s), .streak_sat(streak_sat_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m);
    case (m)
      2'd0:    return ~(x ^ y);
      2'd1:    return x & y;
      2'd2:    return x | y;
      default: return x ^ y;
    endcase
  endfunction

  function automatic int next_streak(input int cur, input int maxv, input logic v,
                                     input logic eq, input logic clr);
    if (clr) return (v && eq) ? 1 : 0;
    if (v) return eq ? ((cur < maxv) ? cur + 1 : maxv) : 0;
    return cur;
  endfunction

  task automatic model(input logic r, input logic v, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [1:0] im, input logic ic);
    rec_t rc;
    logic pv;
    logic eq;
    pv = 1'b0;
    eq = 1'b0;
    if (r) begin
      q.delete();
      exp_ov = 0; exp_result = 0; exp_ones = 0; exp_equal = 0;
      exp_streak = 0; exp_streak_s = 0;
    end else begin
      q.push_back('{v: v, a: ia, b: ib, m: im});
      if (q.size() == 2) begin
        rc = q.pop_front();
        pv = rc.v;
        eq = (rc.a == rc.b);
        if (pv) begin
          exp_result = ref_op(rc.a, rc.b, rc.m);
          exp_ones   = $countones(exp_result);
          exp_equal  = eq;
        end
      end
      exp_ov       = pv;
      exp_streak   = next_streak(exp_streak, 255, pv, eq, ic);
      exp_streak_s = next_streak(exp_streak_s, 3, pv, eq, ic);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [1:0] im, input logic ic);
    rst = r; in_valid = v; a = ia; b = ib; mode = im; clr_streak = ic;
    @(posedge clk);
    #1;
    model(r, v, ia, ib, im, ic);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("result", 32'(result), 32'(exp_result));
    chk("ones", 32'(ones), 32'(exp_ones));
    chk("equal", 32'(equal), 32'(exp_equal));
    chk("streak", 32'(streak), 32'(exp_streak));
    chk("streak_sat", 32'(streak_sat), 32'(exp_streak == 255));
    chk("sat.out_valid", 32'(out_valid_s), 32'(exp_ov));
    chk("sat.streak", 32'(streak_s), 32'(exp_streak_s));
    chk("sat.streak_sat", 32'(streak_sat_s), 32'(exp_streak_s == 3));
  endtask

  task automatic eqs(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 8'h5A + 8'(i), 8'h5A + 8'(i), 2'(i), 0);
  endtask

  task automatic idle(input int n, input logic ic);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 2'd0, ic);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    rst = 1; in_valid = 0; a = 0; b = 0; mode = 0; clr_streak = 0;

    // reset and single-pulse latency
    step(1, 0, 8'h00, 8'h00, 2'd0, 0);
    step(1, 1, 8'h11, 8'h11, 2'd0, 0);
    step(0, 1, 8'hA5, 8'hA5, 2'd0, 0);
    idle(3, 0);

    // all four modes back to back
    for (int m = 0; m < 4; m++) step(0, 1, 8'hF0, 8'h3C, 2'(m), 0);
    idle(2, 0);

    // streak across a bubble, then a mismatch
    eqs(3);
    idle(2, 0);
    eqs(2);
    step(0, 1, 8'h01, 8'h00, 2'd0, 0);
    idle(2, 0);

    // clear colliding with equal, unequal and no sample
    eqs(5);
    step(0, 0, 8'h00, 8'h00, 2'd0, 1);
    idle(1, 0);
    eqs(3);
    step(0, 1, 8'h80, 8'h00, 2'd1, 0);
    step(0, 0, 8'h00, 8'h00, 2'd0, 1);
    idle(1, 0);
    eqs(3);
    idle(2, 0);
    idle(1, 1);
    idle(1, 0);

    // reset with samples in flight
    eqs(4);
    step(1, 1, 8'h77, 8'h77, 2'd0, 0);
    eqs(3);
    idle(3, 0);

    // long saturation run on the narrow counter
    eqs(8);
    step(0, 1, 8'h00, 8'hFF, 2'd2, 0);
    idle(2, 0);

    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? ra : 8'($urandom);
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), ra, rb,
           2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
    end
    idle(3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
